// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package pc_pkg;

  localparam int PC_W   = 12;
  localparam int LUT_AW = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Branch-target LUT bus: the sequencer drives the index, the LUT answers
// combinationally with a signed PC-relative offset.
interface pc_sequencer_if #(
  parameter int D      = 12,
  parameter int LUT_AW = 5
);

  logic [LUT_AW-1:0] lut_addr;
  logic [D-1:0]      lut_target;

  modport master (output lut_addr, input lut_target);
  modport slave  (input lut_addr, output lut_target);

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequential fetch, PC-relative branches through
// an external target LUT, stall/halt handling and a one-cycle post-branch squash.
module pc_sequencer #(
  parameter int D      = pc_pkg::PC_W,
  parameter int LUT_AW = pc_pkg::LUT_AW,
  parameter int CW     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_en,
  input  logic              branch_cond,
  input  logic [LUT_AW-1:0] branch_sel,
  pc_sequencer_if.master    lut,
  output logic [D-1:0]      pc,
  output logic              fetch_valid,
  output logic              branch_taken,
  output logic              done,
  output logic [CW-1:0]     cycle_count
);

  import pc_pkg::*;

  pc_state_t       state, next_state;
  logic [D-1:0]    next_pc;
  logic [CW-1:0]   next_count;
  logic            taken;

  assign lut.lut_addr = branch_sel;
  assign taken        = branch_en & branch_cond;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: each always_comb assigns a default first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = RUN;
      RUN: begin
        if      (halt_req) next_state = DONE;
        else if (stall)    next_state = RUN;
        else if (taken)    next_state = FLUSH;
      end
      FLUSH: next_state = RUN;
      DONE:  if (start) next_state = RUN;
    endcase
  end

  always_comb begin
    fetch_valid = (state == RUN);
  end

  // Next-PC mux and adder; the D-bit sum wraps naturally, matching the
  // two's-complement interpretation of the LUT offset.
  always_comb begin
    next_pc    = pc;
    next_count = cycle_count;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          next_pc    = '0;
          next_count = '0;
        end
      end
      RUN: begin
        if (cycle_count != '1) next_count = cycle_count + CW'(1);
        if (!halt_req && !stall) begin
          if (taken) next_pc = pc + lut.lut_target;
          else       next_pc = pc + D'(1);
        end
      end
      FLUSH: begin
        if (cycle_count != '1) next_count = cycle_count + CW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= '0;
      cycle_count  <= '0;
      branch_taken <= 1'b0;
      done         <= 1'b0;
    end else begin
      pc           <= next_pc;
      cycle_count  <= next_count;
      branch_taken <= (state == RUN) && (next_state == FLUSH);
      done         <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts each cycle's
// outputs into a queue and an independent monitor compares the DUT against it.
module tb_pc_sequencer;

  localparam int D      = 12;
  localparam int LUT_AW = 5;
  localparam int TB_CW  = 8;
  localparam int CC_MAX = (1 << TB_CW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;
  localparam int M_DONE  = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0, stall = 1'b0, halt_req = 1'b0;
  logic              branch_en = 1'b0, branch_cond = 1'b0;
  logic [LUT_AW-1:0] branch_sel = '0;
  logic [D-1:0]      pc;
  logic              fetch_valid, branch_taken, done;
  logic [TB_CW-1:0]  cycle_count;
  logic [D-1:0]      lut_mem [32];

  pc_sequencer_if #(.D(D), .LUT_AW(LUT_AW)) lut_if ();

  assign lut_if.lut_target = lut_mem[lut_if.lut_addr];

  pc_sequencer #(.D(D), .LUT_AW(LUT_AW), .CW(TB_CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stall        (stall),
    .halt_req     (halt_req),
    .branch_en    (branch_en),
    .branch_cond  (branch_cond),
    .branch_sel   (branch_sel),
    .lut          (lut_if.master),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .branch_taken (branch_taken),
    .done         (done),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int fv;
    int bt;
    int dn;
    int cc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_mode = M_IDLE;
  int   m_pc = 0;
  int   m_cc = 0;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.pc = m_pc;
    e.fv = (m_mode == M_RUN)   ? 1 : 0;
    e.bt = (m_mode == M_FLUSH) ? 1 : 0;
    e.dn = (m_mode == M_DONE)  ? 1 : 0;
    e.cc = m_cc;
    return e;
  endfunction

  // Monitor: runs after the stimulus has pushed its prediction for the next edge,
  // so the queue head always describes the cycle currently on the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",           int'(pc),           e.pc);
        check("fetch_valid",  int'(fetch_valid),  e.fv);
        check("branch_taken", int'(branch_taken), e.bt);
        check("done",         int'(done),         e.dn);
        check("cycle_count",  int'(cycle_count),  e.cc);
      end
    end
  end

  // One cycle of stimulus; the model advances by the architectural rules.
  task automatic step(input bit st, input bit sl, input bit hr,
                      input bit be, input bit bc, input int sel);
    int tgt;
    @(posedge clk);
    #1;
    start = st; stall = sl; halt_req = hr;
    branch_en = be; branch_cond = bc; branch_sel = LUT_AW'(sel);
    #1;
    check("lut_addr", int'(lut_if.lut_addr), sel);
    tgt = int'($signed(lut_mem[sel]));
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (st) begin
          m_mode = M_RUN; m_pc = 0; m_cc = 0;
        end
      end
      M_RUN: begin
        m_cc = (m_cc < CC_MAX) ? m_cc + 1 : CC_MAX;
        if (hr)           m_mode = M_DONE;
        else if (sl)      m_mode = M_RUN;
        else if (be && bc) begin
          m_pc   = (((m_pc + tgt) % 4096) + 4096) % 4096;
          m_mode = M_FLUSH;
        end else          m_pc = (m_pc + 1) % 4096;
      end
      default: begin
        m_cc   = (m_cc < CC_MAX) ? m_cc + 1 : CC_MAX;
        m_mode = M_RUN;
      end
    endcase
    exp_q.push_back(model_view());
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Uses LUT slot 20 to reach an arbitrary PC with one taken branch and its squash.
  task automatic jump_to(input int dest);
    lut_mem[20] = D'((dest - m_pc) & 4095);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20);
    idle_step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #5;
    reset_n = 1'b0;
    start = 0; stall = 0; halt_req = 0; branch_en = 0; branch_cond = 0; branch_sel = '0;
    exp_q.delete();
    #1;
    check("rst_pc",           int'(pc),           0);
    check("rst_fetch_valid",  int'(fetch_valid),  0);
    check("rst_branch_taken", int'(branch_taken), 0);
    check("rst_done",         int'(done),         0);
    check("rst_cycle_count",  int'(cycle_count),  0);
    m_mode = M_IDLE; m_pc = 0; m_cc = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(model_view());
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut_mem[i] = D'($urandom);
    lut_mem[0]  = '0;
    lut_mem[7]  = D'(126);
    lut_mem[12] = D'(-236);

    do_reset();

    // Start, then plain sequential fetch
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) idle_step();
    while (m_pc != 10) idle_step();

    // Forward branch 10 -> 136, halt during the squash is ignored
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_step();

    // Backward branch 300 -> 64, then not-taken at 300 -> 301
    jump_to(300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12);
    idle_step();
    jump_to(300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12);
    idle_step();

    // Priority: stall beats branch, halt beats branch
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12);
    idle_step();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_step();

    // Wrap at the top of the PC range and a zero offset
    jump_to(4095);
    idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle_step();

    // Counter saturation
    repeat (CC_MAX + 5) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) lut_mem[$urandom_range(1, 31)] = D'($urandom);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)));
    end

    // Asynchronous reset while running, then a clean restart
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_step();
    idle_step();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) idle_step();

    @(posedge clk);
    #4;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
